// File: rtl/controle_fechadura.sv
// Top-level sequencing FSM of the electronic lock: launches one validator comparison per
// completed entry, then drives unlock timing, error feedback, failure counting and lockout.
module controle_fechadura #(
    parameter int PW_W      = 16,
    parameter int MAX_TENT  = 3,
    parameter int T_ABERTO  = 5000,
    parameter int T_ERRO    = 100,
    parameter int T_BLOQ    = 30000,
    parameter int T_TIMEOUT = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          senha_pronta,
    input  logic [PW_W-1:0]               senha_in,
    input  logic                          trancar,
    input  logic                          val_done,
    input  logic                          val_ok,
    output logic                          val_enable,
    output logic [PW_W-1:0]               val_senha,
    output logic                          tranca,
    output logic                          erro,
    output logic                          bloqueado,
    output logic [$clog2(MAX_TENT+1)-1:0] tentativas
);

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    localparam int TMAX  = max3(T_ABERTO, T_ERRO, T_BLOQ);
    localparam int TIM_W = $clog2(TMAX + 1);
    localparam int WAI_W = $clog2(T_TIMEOUT + 1);
    localparam int TEN_W = $clog2(MAX_TENT + 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        VALIDA   = 3'd1,
        ABERTO   = 3'd2,
        ERRO     = 3'd3,
        BLOQUEIO = 3'd4
    } estado_t;

    estado_t           state_q, state_d;
    logic [TIM_W-1:0]  timer_q, timer_d;
    logic [WAI_W-1:0]  wait_q, wait_d;
    logic [TEN_W-1:0]  tent_q, tent_d;
    logic [PW_W-1:0]   senha_q, senha_d;
    logic              val_enable_q, val_enable_d;
    logic              tranca_q, tranca_d;
    logic              erro_q, erro_d;
    logic              bloqueado_q, bloqueado_d;

    logic              falha;
    logic [TEN_W:0]    tent_inc;
    logic              tent_limite;

    // One extra bit so the increment can be compared against MAX_TENT without wrapping.
    assign tent_inc    = {1'b0, tent_q} + {{TEN_W{1'b0}}, 1'b1};
    assign tent_limite = (tent_inc >= (TEN_W+1)'(MAX_TENT));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            timer_q      <= '0;
            wait_q       <= '0;
            tent_q       <= '0;
            senha_q      <= '0;
            val_enable_q <= 1'b0;
            tranca_q     <= 1'b1;
            erro_q       <= 1'b0;
            bloqueado_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            wait_q       <= wait_d;
            tent_q       <= tent_d;
            senha_q      <= senha_d;
            val_enable_q <= val_enable_d;
            tranca_q     <= tranca_d;
            erro_q       <= erro_d;
            bloqueado_q  <= bloqueado_d;
        end
    end

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        wait_d  = wait_q;
        tent_d  = tent_q;
        senha_d = senha_q;
        falha   = 1'b0;

        case (state_q)
            IDLE: begin
                timer_d = '0;
                if (senha_pronta) begin
                    senha_d = senha_in;
                    wait_d  = '0;
                    state_d = VALIDA;
                end
            end

            VALIDA: begin
                // A result on the final wait cycle takes priority over the timeout.
                if (val_done) begin
                    if (val_ok) begin
                        state_d = ABERTO;
                        tent_d  = '0;
                        timer_d = TIM_W'(T_ABERTO);
                    end else begin
                        falha = 1'b1;
                    end
                end else if (wait_q == WAI_W'(T_TIMEOUT - 1)) begin
                    falha = 1'b1;
                end else begin
                    wait_d = wait_q + 1'b1;
                end

                if (falha) begin
                    if (tent_limite) begin
                        tent_d  = TEN_W'(MAX_TENT);
                        state_d = BLOQUEIO;
                        timer_d = TIM_W'(T_BLOQ);
                    end else begin
                        tent_d  = tent_inc[TEN_W-1:0];
                        state_d = ERRO;
                        timer_d = TIM_W'(T_ERRO);
                    end
                end
            end

            ABERTO: begin
                if (trancar || timer_q == TIM_W'(1)) begin
                    state_d = IDLE;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end

            ERRO: begin
                if (timer_q == TIM_W'(1)) begin
                    state_d = IDLE;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end

            BLOQUEIO: begin
                if (timer_q == TIM_W'(1)) begin
                    state_d = IDLE;
                    timer_d = '0;
                    tent_d  = '0;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
                timer_d = '0;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with the state register.
    always_comb begin
        val_enable_d = (state_q == IDLE) && senha_pronta;
        tranca_d     = (state_d != ABERTO);
        erro_d       = (state_d == ERRO);
        bloqueado_d  = (state_d == BLOQUEIO);
    end

    assign val_enable = val_enable_q;
    assign val_senha  = senha_q;
    assign tranca     = tranca_q;
    assign erro       = erro_q;
    assign bloqueado  = bloqueado_q;
    assign tentativas = tent_q;

endmodule

// File: tb/tb_controle_fechadura.sv
// Directed bench for controle_fechadura: passwords pushed to a queue on entry are popped
// and compared whenever the lock issues a validator start pulse.
module tb_controle_fechadura;

    logic        clk;
    logic        rst;
    logic        senha_pronta;
    logic [15:0] senha_in;
    logic        trancar;
    logic        val_done;
    logic        val_ok;
    logic        val_enable;
    logic [15:0] val_senha;
    logic        tranca;
    logic        erro;
    logic        bloqueado;
    logic [1:0]  tentativas;

    int n_tests = 0;
    int n_fail  = 0;
    logic [15:0] exp_q[$];

    controle_fechadura dut (
        .clk          (clk),
        .rst          (rst),
        .senha_pronta (senha_pronta),
        .senha_in     (senha_in),
        .trancar      (trancar),
        .val_done     (val_done),
        .val_ok       (val_ok),
        .val_enable   (val_enable),
        .val_senha    (val_senha),
        .tranca       (tranca),
        .erro         (erro),
        .bloqueado    (bloqueado),
        .tentativas   (tentativas)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every validator start must present the next queued password.
    always @(negedge clk) begin
        if (!rst && val_enable === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_val_enable", 32'(val_enable), 32'd0);
            end else begin
                logic [15:0] e;
                e = exp_q.pop_front();
                chk("val_senha", 32'(val_senha), 32'(e));
            end
        end
    end

    task automatic send_pw(input logic [15:0] pw);
        senha_in     = pw;
        senha_pronta = 1'b1;
        exp_q.push_back(pw);
        tick();
        senha_pronta = 1'b0;
        chk("val_enable_rise", 32'(val_enable), 32'd1);
    endtask

    task automatic respond(input logic ok);
        tick();
        chk("val_enable_fall", 32'(val_enable), 32'd0);
        val_done = 1'b1;
        val_ok   = ok;
        tick();
        val_done = 1'b0;
        val_ok   = 1'b0;
    endtask

    task automatic fail_once(input logic [15:0] pw, input int exp_tent);
        int n;
        send_pw(pw);
        respond(1'b0);
        chk("tentativas_fail", 32'(tentativas), 32'(exp_tent));
        if (exp_tent < 3) begin
            n = 0;
            while (erro === 1'b1 && n < 200) begin
                tick();
                n++;
            end
            chk("erro_cycles", 32'(n), 32'd100);
        end else begin
            chk("bloqueado_on", 32'(bloqueado), 32'd1);
            chk("erro_off_in_bloq", 32'(erro), 32'd0);
            chk("tranca_in_bloq", 32'(tranca), 32'd1);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        rst          = 1'b0;
        senha_pronta = 1'b0;
        senha_in     = '0;
        trancar      = 1'b0;
        val_done     = 1'b0;
        val_ok       = 1'b0;
        #1 rst = 1'b1;
        tick();
        tick();
        chk("rst_tranca", 32'(tranca), 32'd1);
        chk("rst_val_enable", 32'(val_enable), 32'd0);
        chk("rst_erro", 32'(erro), 32'd0);
        chk("rst_bloqueado", 32'(bloqueado), 32'd0);
        chk("rst_tentativas", 32'(tentativas), 32'd0);
        chk("rst_val_senha", 32'(val_senha), 32'd0);
        rst = 1'b0;
        tick();

        // Correct password, full open period
        send_pw(16'h1234);
        respond(1'b1);
        chk("aberto_tentativas", 32'(tentativas), 32'd0);
        n = 0;
        while (tranca === 1'b0 && n < 6000) begin
            tick();
            n++;
        end
        chk("aberto_cycles", 32'(n), 32'd5000);
        chk("tranca_after_open", 32'(tranca), 32'd1);

        // Stray validator result while idle must not open
        val_done = 1'b1;
        val_ok   = 1'b1;
        tick();
        val_done = 1'b0;
        val_ok   = 1'b0;
        tick();
        chk("val_done_idle_ignored", 32'(tranca), 32'd1);

        // Early relock at cycle 100 of ABERTO
        send_pw(16'h5678);
        respond(1'b1);
        repeat (99) tick();
        chk("still_open_before_trancar", 32'(tranca), 32'd0);
        trancar = 1'b1;
        tick();
        trancar = 1'b0;
        chk("early_relock", 32'(tranca), 32'd1);

        // Three wrong passwords, lockout with ignored entries
        fail_once(16'h9abc, 1);
        fail_once(16'h0001, 2);
        fail_once(16'h0002, 3);
        n = 0;
        while (bloqueado === 1'b1 && n < 40000) begin
            senha_pronta = (n == 5 || n == 1000);
            tick();
            n++;
        end
        senha_pronta = 1'b0;
        chk("bloqueio_cycles", 32'(n), 32'd30000);
        chk("tentativas_after_bloq", 32'(tentativas), 32'd0);
        chk("tranca_after_bloq", 32'(tranca), 32'd1);

        // Validator timeout
        send_pw(16'h1111);
        n = 0;
        while (erro !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        chk("timeout_cycles", 32'(n), 32'd16);
        chk("timeout_tentativas", 32'(tentativas), 32'd1);
        n = 0;
        while (erro === 1'b1 && n < 200) begin
            tick();
            n++;
        end

        // Result on the last wait cycle wins over timeout
        send_pw(16'h2222);
        repeat (15) tick();
        val_done = 1'b1;
        val_ok   = 1'b1;
        tick();
        val_done = 1'b0;
        val_ok   = 1'b0;
        chk("last_cycle_open", 32'(tranca), 32'd0);
        chk("last_cycle_no_erro", 32'(erro), 32'd0);
        chk("last_cycle_tentativas", 32'(tentativas), 32'd0);
        trancar = 1'b1;
        tick();
        trancar = 1'b0;

        // Two failures then success clears the count
        fail_once(16'h3333, 1);
        fail_once(16'h4444, 2);
        send_pw(16'h5555);
        respond(1'b1);
        chk("success_clears", 32'(tentativas), 32'd0);
        chk("success_open", 32'(tranca), 32'd0);

        // Asynchronous reset during ABERTO
        repeat (10) tick();
        rst = 1'b1;
        #1;
        chk("rst_aberto_tranca", 32'(tranca), 32'd1);
        chk("rst_aberto_tentativas", 32'(tentativas), 32'd0);
        tick();
        rst = 1'b0;
        tick();

        // Asynchronous reset during BLOQUEIO
        fail_once(16'h6666, 1);
        fail_once(16'h7777, 2);
        fail_once(16'h8888, 3);
        repeat (50) tick();
        rst = 1'b1;
        #1;
        chk("rst_bloq_bloqueado", 32'(bloqueado), 32'd0);
        chk("rst_bloq_tranca", 32'(tranca), 32'd1);
        chk("rst_bloq_tentativas", 32'(tentativas), 32'd0);
        tick();
        rst = 1'b0;
        tick();

        // IDLE after release: a new entry is accepted
        send_pw(16'h4321);
        respond(1'b1);
        chk("after_rst_open", 32'(tranca), 32'd0);
        tick();
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/controle_fechadura.md
Name: controle_fechadura

Overview:
- Top-level sequencing FSM of the electronic lock.
- Accepts a completed password entry from the keypad front-end and launches one comparison on the password validator (validaSenha) via enable/result handshake.
- Drives the lock actuator: unlock timing, error feedback, failed-attempt counting and timed lockout after repeated failures.
- Sits between keypad/entry logic and validator, actuator and status LEDs.

Parameters:
- PW_W, 16, width of packed password bus (4 BCD digits).
- MAX_TENT, 3, consecutive failures that trigger lockout (≥1).
- T_ABERTO, 5000, cycles the lock stays released.
- T_ERRO, 100, cycles the error indication is shown.
- T_BLOQ, 30000, lockout duration in cycles.
- T_TIMEOUT, 16, max cycles to wait for validator result.

Ports:
- clk, in, 1, system clock, all logic on rising edge.
- rst, in, 1, asynchronous active-high reset.
- senha_pronta, in, 1, single-cycle pulse: entry complete, senha_in valid.
- senha_in, in, PW_W, entered password, sampled only with senha_pronta.
- trancar, in, 1, pulse: relock immediately while open.
- val_done, in, 1, validator result strobe.
- val_ok, in, 1, validator verdict, meaningful only with val_done.
- val_enable, out, 1, one-cycle start pulse to validator.
- val_senha, out, PW_W, latched password presented to validator.
- tranca, out, 1, 1 = actuator locked.
- erro, out, 1, wrong-password indication.
- bloqueado, out, 1, lockout active.
- tentativas, out, clog2(MAX_TENT+1), current consecutive-failure count.

Behaviour:
- Reset (async, any state, mid-operation included):
  - State IDLE; tranca=1.
  - val_enable, erro and bloqueado = 0.
  - tentativas=0; val_senha=0; timers=0.
- All outputs registered; state/outputs change only on rising clk.
- States: IDLE, VALIDA, ABERTO, ERRO, BLOQUEIO.
- IDLE:
  - senha_pronta=1 at edge k → senha_in latched into val_senha.
  - State=VALIDA from edge k+1.
  - val_enable=1 during exactly cycle k+1 only.
- VALIDA:
  - val_senha held stable.
  - Wait counter starts at 0 on entry.
  - val_done=1 & val_ok=1 → ABERTO; tentativas←0; timer←T_ABERTO.
  - val_done=1 & val_ok=0 → failure.
  - No val_done within T_TIMEOUT cycles of VALIDA → failure.
  - val_done arriving on the last timeout cycle is honoured (result wins over timeout).
- Failure handling:
  - tentativas←tentativas+1.
  - New value = MAX_TENT → BLOQUEIO, timer←T_BLOQ.
  - Otherwise → ERRO, timer←T_ERRO.
  - tentativas saturates at MAX_TENT.
- ABERTO:
  - tranca=0.
  - Lasts exactly T_ABERTO cycles, then IDLE with tranca=1.
  - trancar=1 → IDLE next edge with tranca=1 (early relock).
- ERRO: erro=1 for exactly T_ERRO cycles → IDLE.
- BLOQUEIO:
  - bloqueado=1, erro=0, tranca=1.
  - Exactly T_BLOQ cycles, then tentativas←0 → IDLE.
- Ignored inputs:
  - senha_pronta ignored (no latch, no val_enable) in every state except IDLE.
  - trancar ignored outside ABERTO.
  - val_done outside VALIDA ignored.
- Timers: count down, reload on state entry; transition on the cycle the count reaches 1, giving exactly T cycles in-state. Width clog2(max T + 1).
- tranca=0 only in ABERTO. erro and bloqueado are never 1 simultaneously.

Test Plan:
- Correct password: reset, senha_pronta with senha_in=16'h1234; val_done=1, val_ok=1 two cycles after val_enable.
  - Expect one-cycle val_enable and val_senha=16'h1234.
  - Expect tranca=0 for exactly 5000 cycles, then tranca=1 and IDLE.
- Early relock: same as above, then trancar pulse at cycle 100 of ABERTO → tranca=1 next edge; following senha_pronta accepted.
- Three wrong passwords (val_ok=0):
  - erro=1 for 100 cycles after each of the first two; tentativas=1, 2.
  - Third failure → bloqueado=1 for 30000 cycles; senha_pronta pulses during lockout produce no val_enable.
  - After lockout, tentativas=0.
- Validator timeout: never assert val_done → failure after 16 VALIDA cycles, erro=1, tentativas=1. val_done=1/val_ok=1 exactly at cycle 16 → ABERTO instead.
- Success clears count: two failures then a success → tentativas=0, tranca=0.
- Reset mid-operation: assert rst during ABERTO and during BLOQUEIO → tranca=1, bloqueado=0, tentativas=0 immediately (asynchronously), IDLE after release.
